pa_ram_stream_src: RTL and testbench

- Memory-side responder for the sorter's streaming RAM read protocol.
- On i_start it latches an inclusive address window [i_addr_si, i_addr_ei] from an internal buffer.
- It then returns one word per accepted i_en_ram request as o_data_ram/o_valid_ram, with fixed latency, until the window is exhausted.
- A separate write port loads the buffer. Consumers are the mean-calculation and partition stages.

---
 rtl/pa_pkg.sv | 13 +
 rtl/pa_sdp_ram.sv | 27 ++
 rtl/pa_ram_stream_src.sv | 127 ++++++++++++
 tb/tb_pa_ram_stream_src.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// Shared types and constants for the streaming RAM read responder and its consumers.
package pa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } stream_state_e;

  // Cycles from an accepted request to its o_valid_ram; consumers size timeouts from this.
  localparam int RD_LATENCY = 2;

endpackage : pa_pkg

// File: rtl/pa_sdp_ram.sv
// Simple dual-port buffer: one write port, one registered read port, read-before-write on collision.
module pa_sdp_ram #(
  parameter int DEPTH_LOG2 = 8,
  parameter int SIZE_DATA  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [SIZE_DATA-1:0]  i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [SIZE_DATA-1:0]  o_rd_data
);

  logic [SIZE_DATA-1:0] r_mem [2**DEPTH_LOG2];
  logic [SIZE_DATA-1:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto block RAM; non-blocking writes make a
  // same-cycle read see the old word, which is the read-before-write behaviour we want.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule : pa_sdp_ram

// File: rtl/pa_ram_stream_src.sv
// Memory-side responder: latches an inclusive address window on i_start and returns one
// word per accepted i_en_ram, two cycles later, until the window is exhausted.
module pa_ram_stream_src
  import pa_pkg::*;
#(
  parameter int SIZE_ADDR  = 32,
  parameter int SIZE_DATA  = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [SIZE_ADDR-1:0]  i_addr_si,
  input  logic [SIZE_ADDR-1:0]  i_addr_ei,
  input  logic                  i_en_ram,
  output logic [SIZE_DATA-1:0]  o_data_ram,
  output logic                  o_valid_ram,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [SIZE_DATA-1:0]  i_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  stream_state_e        r_state;
  stream_state_e        w_state_nxt;
  logic [SIZE_ADDR-1:0] r_rd_ptr;
  logic [SIZE_ADDR-1:0] r_end_ptr;
  logic                 r_v1;
  logic                 r_v2;
  logic [SIZE_DATA-1:0] r_data;
  logic                 r_err;
  logic [SIZE_DATA-1:0] w_ram_q;
  logic                 w_start_ok;
  logic                 w_last;
  logic                 w_rd_en;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_done;

  // Full-width compare: any address bit above the buffer index makes the window invalid.
  assign w_start_ok = (i_addr_si <= i_addr_ei) && ((i_addr_ei >> DEPTH_LOG2) == '0);
  assign w_last     = (r_rd_ptr == r_end_ptr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          if (w_start_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = STREAM;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      STREAM: begin
        if (i_en_ram) begin
          w_rd_en = 1'b1;
          if (w_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_v1 && !r_v2) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr  <= '0;
      r_end_ptr <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd_ptr  <= i_addr_si;
        r_end_ptr <= i_addr_ei;
      end else if (w_rd_en && !w_last) begin
        r_rd_ptr <= r_rd_ptr + SIZE_ADDR'(1);
      end
      r_v1  <= w_rd_en;
      r_v2  <= r_v1;
      r_err <= w_reject;
      if (r_v1) r_data <= w_ram_q;
    end
  end

  pa_sdp_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .SIZE_DATA  (SIZE_DATA)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rd_data (w_ram_q)
  );

  // Busy falls in the same cycle that done pulses.
  assign o_busy      = (r_state != IDLE) && !w_done;
  assign o_done      = w_done;
  assign o_err       = r_err;
  assign o_valid_ram = r_v2;
  assign o_data_ram  = r_data;

endmodule : pa_ram_stream_src

// File: tb/tb_pa_ram_stream_src.sv
// Directed bench for pa_ram_stream_src: expected words are queued with their due cycle
// when a request is driven, and a monitor pops and compares every o_valid_ram.
module tb_pa_ram_stream_src;
  import pa_pkg::*;

  localparam int SA = 32;
  localparam int SD = 32;
  localparam int DL = 8;

  typedef struct {
    logic [SD-1:0] data;
    int            due;
  } exp_t;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [SA-1:0] i_addr_si;
  logic [SA-1:0] i_addr_ei;
  logic          i_en_ram;
  logic [SD-1:0] o_data_ram;
  logic          o_valid_ram;
  logic          i_wr_en;
  logic [DL-1:0] i_wr_addr;
  logic [SD-1:0] i_wr_data;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  int   last_req = 0;
  int   dc;
  exp_t sb[$];

  pa_ram_stream_src #(
    .SIZE_ADDR  (SA),
    .SIZE_DATA  (SD),
    .DEPTH_LOG2 (DL)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_addr_si   (i_addr_si),
    .i_addr_ei   (i_addr_ei),
    .i_en_ram    (i_en_ram),
    .o_data_ram  (o_data_ram),
    .o_valid_ram (o_valid_ram),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor samples 2 time units after each rising edge, after the stimulus has driven.
  always @(posedge i_clk) begin
    exp_t e;
    #2;
    if (o_busy) busy_cnt++;
    if (o_valid_ram) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", o_valid_ram, 1'b0);
      end else begin
        e = sb.pop_front();
        check("valid_data", o_data_ram, e.data);
        check("valid_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [DL-1:0] a, input logic [SD-1:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic start(input logic [SA-1:0] si, input logic [SA-1:0] ei);
    i_start   = 1'b1;
    i_addr_si = si;
    i_addr_ei = ei;
    tick();
    i_start   = 1'b0;
  endtask

  // Drive one cycle of i_en_ram; when a word is expected, queue it due RD_LATENCY cycles later.
  task automatic req(input bit en, input bit exp_v, input logic [SD-1:0] d);
    exp_t e;
    i_en_ram = en;
    if (exp_v) begin
      e.data   = d;
      e.due    = cyc + RD_LATENCY;
      last_req = cyc;
      sb.push_back(e);
    end
    tick();
    i_en_ram = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int done_cyc);
    int n = 0;
    while (!o_done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, o_done, 1'b1);
    check({tag, "_busy_at_done"}, o_busy, 1'b0);
    done_cyc = cyc;
    check({tag, "_done_cycle"}, done_cyc, last_req + RD_LATENCY + 1);
    tick();
    check({tag, "_done_one_cycle"}, o_done, 1'b0);
  endtask

  initial begin
    logic [6:0]  gap_pat;
    logic [SD-1:0] gap_dat [4];
    int          gi;

    i_rst_n   = 1'b0;
    i_start   = 1'b0;
    i_addr_si = '0;
    i_addr_ei = '0;
    i_en_ram  = 1'b0;
    i_wr_en   = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    tick();
    tick();
    check("rst_valid", o_valid_ram, 1'b0);
    check("rst_data", o_data_ram, '0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    i_rst_n = 1'b1;
    tick();

    for (int k = 0; k < 16; k++) wr(DL'(k), SD'(k * 3));

    // Basic stream, continuous requests.
    start(4, 7);
    check("basic_busy", o_busy, 1'b1);
    req(1, 1, 12);
    req(1, 1, 15);
    req(1, 1, 18);
    req(1, 1, 21);
    wait_done("basic", dc);

    // Gapped requests, then two extra requests that must be ignored.
    gap_pat    = 7'b1011001;   // applied LSB first: 1,0,0,1,1,0,1
    gap_dat[0] = 12;
    gap_dat[1] = 15;
    gap_dat[2] = 18;
    gap_dat[3] = 21;
    gi = 0;
    start(4, 7);
    for (int k = 0; k < 7; k++) begin
      if (gap_pat[k]) begin
        req(1, 1, gap_dat[gi]);
        gi++;
      end else begin
        req(0, 0, '0);
      end
    end
    req(1, 0, '0);
    req(1, 0, '0);
    wait_done("gapped", dc);

    // Rejected starts.
    start(10, 5);
    check("rej_order_err", o_err, 1'b1);
    check("rej_order_busy", o_busy, 1'b0);
    tick();
    check("rej_order_err_pulse", o_err, 1'b0);
    start(0, 256);
    check("rej_range_err", o_err, 1'b1);
    check("rej_range_busy", o_busy, 1'b0);
    tick();
    check("rej_range_err_pulse", o_err, 1'b0);

    // i_start during an active stream is ignored.
    start(4, 7);
    req(1, 1, 12);
    i_start   = 1'b1;
    i_addr_si = 0;
    i_addr_ei = 1;
    req(1, 1, 15);
    i_start   = 1'b0;
    check("busy_start_no_err", o_err, 1'b0);
    req(1, 1, 18);
    check("busy_start_no_err2", o_err, 1'b0);
    req(1, 1, 21);
    wait_done("busy_start", dc);

    // Write collides with the read of address 6: old data comes back.
    start(4, 7);
    req(1, 1, 12);
    req(1, 1, 15);
    i_wr_en   = 1'b1;
    i_wr_addr = 6;
    i_wr_data = 'h55;
    req(1, 1, 18);
    i_wr_en   = 1'b0;
    req(1, 1, 21);
    wait_done("collide", dc);
    start(6, 6);
    req(1, 1, 'h55);
    wait_done("after_write", dc);

    // Single-word window.
    wr(9, 32'hDEAD_BEEF);
    busy_cnt = 0;
    start(9, 9);
    req(1, 1, 32'hDEAD_BEEF);
    wait_done("single", dc);
    check("single_busy_span", busy_cnt, 3);

    // Reset after two of four words.
    start(0, 3);
    req(1, 1, 0);
    req(1, 1, 3);
    req(1, 0, '0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid_ram, 1'b0);
    check("mid_rst_data", o_data_ram, '0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_done, 1'b0);
    check("mid_rst_err", o_err, 1'b0);
    tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_no_done", o_done, 1'b0);
    end
    start(0, 1);
    req(1, 1, 0);
    req(1, 1, 3);
    wait_done("post_rst", dc);

    tick();
    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pa_ram_stream_src
